// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divider calculation
// (also used by uart_tx) and the default command byte values.
package uart_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [DATA_W-1:0] CMD_LED  = 8'h31;
  localparam logic [DATA_W-1:0] CMD_BEEP = 8'h32;

  // Clock cycles per bit; integer division, so the rate error stays well
  // inside the 2% frame budget for common clock/baud pairs.
  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_cmd_if.sv
// Serial input plus received-byte / command outputs of the UART receiver.
interface uart_rx_cmd_if;
  import uart_pkg::*;

  logic              rx;
  logic [DATA_W-1:0] dout;
  logic              dout_vld;
  logic              frame_err;
  logic              cmd_led;
  logic              cmd_beep;

  // Receiver side: consumes the line, drives byte and command outputs.
  modport master (
    input  rx,
    output dout, dout_vld, frame_err, cmd_led, cmd_beep
  );

  // Host side: drives the line, observes the outputs.
  modport slave (
    output rx,
    input  dout, dout_vld, frame_err, cmd_led, cmd_beep
  );

endinterface

// File: rtl/uart_cmd_dec.sv
// Registered command decoder: one-cycle pulse per recognised byte value,
// issued one clock after the byte strobe.
module uart_cmd_dec #(
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  CMD_LED  = 8'h31,
  parameter logic [DATA_W-1:0]  CMD_BEEP = 8'h32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              din_vld,
  output logic              cmd_led,
  output logic              cmd_beep
);
  import uart_pkg::*;

  // Compare the byte against each command only while its strobe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_led  <= 1'b0;
      cmd_beep <= 1'b0;
    end else begin
      cmd_led  <= din_vld && (din == CMD_LED);
      cmd_beep <= din_vld && (din == CMD_BEEP);
    end
  end

endmodule

// File: rtl/uart_rx_cmd.sv
// 8N1 UART receiver with mid-bit sampling, start/stop validation and a small
// command decoder. Outputs are aligned so dout, dout_vld and cmd_* coincide.
module uart_rx_cmd #(
  parameter int          CLK_FREQ = 50_000_000,
  parameter int          BAUD     = 115200,
  parameter logic [7:0]  CMD_LED  = uart_pkg::CMD_LED,
  parameter logic [7:0]  CMD_BEEP = uart_pkg::CMD_BEEP
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_rx_cmd_if.master bus
);
  import uart_pkg::*;

  localparam int BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int BIT_HALF = BAUD_DIV / 2;
  localparam int CNT_W    = $clog2(BAUD_DIV);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);

  logic rx_p0, rx_p1, rx_p2;
  logic start_edge;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  baud_cnt, baud_cnt_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic              shift_en;
  logic              load_byte;
  logic              stop_bad;
  logic [DATA_W-1:0] shift;

  logic              vld_p0, err_p0;
  logic [DATA_W-1:0] byte_p0;
  logic              vld_p1, err_p1;
  logic [DATA_W-1:0] dout_p1;

  // Synchronizer and edge register; cleared to 0 so a line already low at
  // reset release is not mistaken for a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_p0 <= 1'b0;
      rx_p1 <= 1'b0;
      rx_p2 <= 1'b0;
    end else begin
      rx_p0 <= bus.rx;
      rx_p1 <= rx_p0;
      rx_p2 <= rx_p1;
    end
  end

  assign start_edge = rx_p2 & ~rx_p1;

  // FSM state and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
    end
  end

  // Next-state logic: half-bit wait to validate the start bit, then one full
  // bit period per data bit and for the stop bit.
  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_cnt_nxt  = bit_cnt;
    shift_en     = 1'b0;
    load_byte    = 1'b0;
    stop_bad     = 1'b0;
    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        bit_cnt_nxt  = '0;
        if (start_edge) state_nxt = START;
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_cnt_nxt = '0;
          state_nxt    = rx_p1 ? IDLE : DATA;
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_nxt = '0;
          shift_en     = 1'b1;
          bit_cnt_nxt  = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nxt = STOP;
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_cnt == BIT_LAST) begin
          baud_cnt_nxt = '0;
          load_byte    = rx_p1;
          stop_bad     = ~rx_p1;
          state_nxt    = IDLE;
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data shift register, LSB first; a partial byte is simply overwritten.
  always_ff @(posedge clk) begin
    if (shift_en) shift[bit_cnt] <= rx_p1;
  end

  // ---- stage p0: frame result registered ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0  <= 1'b0;
      err_p0  <= 1'b0;
      byte_p0 <= '0;
    end else begin
      vld_p0 <= load_byte;
      err_p0 <= stop_bad;
      if (load_byte) byte_p0 <= shift;
    end
  end

  uart_cmd_dec #(
    .DATA_W   (DATA_W),
    .CMD_LED  (CMD_LED),
    .CMD_BEEP (CMD_BEEP)
  ) u_cmd_dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .din      (byte_p0),
    .din_vld  (vld_p0),
    .cmd_led  (bus.cmd_led),
    .cmd_beep (bus.cmd_beep)
  );

  // ---- stage p1: delay byte outputs to line up with the decoder pulses ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      err_p1  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      vld_p1  <= vld_p0;
      err_p1  <= err_p0;
      dout_p1 <= byte_p0;
    end
  end

  assign bus.dout      = dout_p1;
  assign bus.dout_vld  = vld_p1;
  assign bus.frame_err = err_p1;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Scoreboard bench for uart_rx_cmd at default parameters (434 clocks/bit).
module tb_uart_rx_cmd;
  import uart_pkg::*;

  localparam int BIT_T   = 434;
  localparam int LAT     = 4126;
  localparam int LAT_TOL = 2;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    logic       led;
    logic       beep;
    int         t0;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb[$];

  uart_rx_cmd_if bus ();

  uart_rx_cmd dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic err, input logic [7:0] d, input logic led, input logic beep);
    exp_t e;
    e.is_err = err;
    e.data   = d;
    e.led    = led;
    e.beep   = beep;
    e.t0     = 0;
    return e;
  endfunction

  task automatic drive_bit(input logic v, input int n);
    @(posedge clk);
    #1 bus.rx = v;
    repeat (n - 1) @(posedge clk);
  endtask

  // Start bit, 8 data bits LSB first, stop bit of the given level.
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input exp_t e);
    @(posedge clk);
    #1 bus.rx = 1'b0;
    e.t0 = cyc;
    sb.push_back(e);
    repeat (BIT_T - 1) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(b[i], BIT_T);
    drive_bit(stop_v, BIT_T);
  endtask

  // Monitor: pops the scoreboard whenever the DUT strobes a byte or error.
  initial begin
    exp_t e;
    int   d;
    forever begin
      @(negedge clk);
      if (!bus.dout_vld && (bus.cmd_led || bus.cmd_beep))
        chk("cmd_without_vld", {30'd0, bus.cmd_led, bus.cmd_beep}, 32'd0);
      if (bus.dout_vld || bus.frame_err) begin
        chk("vld_err_exclusive", {31'd0, bus.dout_vld & bus.frame_err}, 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got vld=%0b err=%0b dout=%0h expected none (cycle %0d)",
                   bus.dout_vld, bus.frame_err, bus.dout, cyc);
        end else begin
          e = sb.pop_front();
          d = cyc - e.t0;
          chk("event_kind",  {31'd0, bus.frame_err}, {31'd0, e.is_err});
          chk("dout",        {24'd0, bus.dout},      {24'd0, e.data});
          chk("cmd_led",     {31'd0, bus.cmd_led},   {31'd0, e.led});
          chk("cmd_beep",    {31'd0, bus.cmd_beep},  {31'd0, e.beep});
          checks++;
          if (d < LAT - LAT_TOL || d > LAT + LAT_TOL) begin
            errors++;
            $display("FAIL latency: got %0d expected %0d+-%0d", d, LAT, LAT_TOL);
          end
        end
      end
    end
  end

  initial begin
    int g0;
    cyc    = 0;
    checks = 0;
    errors = 0;
    bus.rx = 1'b0;
    rst_n  = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;

    // Line low at reset release must not start a frame.
    repeat (600) @(posedge clk);
    #1 bus.rx = 1'b1;

    // Idle line.
    repeat (10000) @(posedge clk);
    @(negedge clk);
    chk("idle_dout",      {24'd0, bus.dout}, 32'd0);
    chk("idle_dout_vld",  {31'd0, bus.dout_vld}, 32'd0);
    chk("idle_frame_err", {31'd0, bus.frame_err}, 32'd0);
    chk("idle_cmds",      {30'd0, bus.cmd_led, bus.cmd_beep}, 32'd0);

    // Plain byte, no command.
    send_frame(8'hA5, 1'b1, mk(1'b0, 8'hA5, 1'b0, 1'b0));
    repeat (1000) @(posedge clk);

    // Back-to-back commands.
    send_frame(8'h31, 1'b1, mk(1'b0, 8'h31, 1'b1, 1'b0));
    send_frame(8'h32, 1'b1, mk(1'b0, 8'h32, 1'b0, 1'b1));
    repeat (1000) @(posedge clk);

    // Framing error, then break: dout holds 8'h32, no command.
    send_frame(8'h31, 1'b0, mk(1'b1, 8'h32, 1'b0, 1'b0));
    repeat (5000) @(posedge clk);
    #1 bus.rx = 1'b1;
    repeat (1000) @(posedge clk);
    @(negedge clk);
    chk("after_break_dout", {24'd0, bus.dout}, 32'h32);

    // 100-cycle glitch rejected by the start-bit check.
    @(posedge clk);
    #1 bus.rx = 1'b0;
    g0 = cyc;
    repeat (99) @(posedge clk);
    #1 bus.rx = 1'b1;
    while (cyc < g0 + 50) @(posedge clk);
    @(negedge clk);
    chk("glitch_in_start", {30'd0, dut.state}, {30'd0, START});
    while (cyc < g0 + 230) @(posedge clk);
    @(negedge clk);
    chk("glitch_back_idle", {30'd0, dut.state}, {30'd0, IDLE});
    repeat (1000) @(posedge clk);

    // Reset during bit 4 of 8'h31 (bits LSB first: 1,0,0,0,1).
    @(posedge clk);
    #1 bus.rx = 1'b0;
    repeat (BIT_T - 1) @(posedge clk);
    drive_bit(1'b1, BIT_T);
    drive_bit(1'b0, BIT_T);
    drive_bit(1'b0, BIT_T);
    drive_bit(1'b0, BIT_T);
    drive_bit(1'b1, 200);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_dout",  {24'd0, bus.dout}, 32'd0);
    chk("rst_state", {30'd0, dut.state}, {30'd0, IDLE});
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (1000) @(posedge clk);

    send_frame(8'h55, 1'b1, mk(1'b0, 8'h55, 1'b0, 1'b0));

    // Drain scoreboard with a bounded wait.
    for (int i = 0; i < 5000 && sb.size() != 0; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd.md
# uart_rx_cmd

Receives 8N1 UART bytes from the PC on the `rx` pin, the opposite direction of the temperature byte stream sent by `uart_tx`. Each byte is sampled at mid-bit and checked for a valid start bit and stop bit. The block emits each received byte with a one-cycle valid strobe and decodes a small command set into single-cycle pulses for the top level. It replaces the top level's raw `rx == 0` LED-toggle detection, which mis-fires on every zero bit.

## Interface

Parameters:
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate.
- `CMD_LED`, default 8'h31: byte value that toggles LED2.
- `CMD_BEEP`, default 8'h32: byte value that requests the beep mute toggle.

Derived constants:
- `BAUD_DIV` = CLK_FREQ/BAUD, which is 434 at the defaults.
- `BIT_HALF` = BAUD_DIV/2, which is 217 at the defaults.

Ports:
- `clk`  input  1: system clock.
- `rst_n`  input  1: reset, asynchronous, active-low.
- `rx`  input  1: asynchronous serial line. Idles high.
- `dout`  output  8: last correctly received byte. Holds its value until the next valid byte.
- `dout_vld`  output  1: one-cycle pulse when `dout` is updated.
- `frame_err`  output  1: one-cycle pulse when the stop bit is sampled low.
- `cmd_led`  output  1: one-cycle pulse, coincident with `dout_vld`, when the byte equals `CMD_LED`.
- `cmd_beep`  output  1: one-cycle pulse, coincident with `dout_vld`, when the byte equals `CMD_BEEP`.

## Operation

Input conditioning:
- `rx` passes through a 2-FF synchronizer, then a third register for edge detection.
- A start edge is the synchronized value going from 1 to 0.

State machine (states IDLE, START, DATA, STOP):
- IDLE: `bit_cnt` = 0 and `baud_cnt` = 0. On a start edge, go to START.
- START: `baud_cnt` counts up. At `baud_cnt` == BIT_HALF-1, sample the line.
  - Line low: clear `baud_cnt` and go to DATA.
  - Line high: glitch or false start. Go to IDLE with no output.
- DATA: at `baud_cnt` == BAUD_DIV-1, sample the line into `shift[bit_cnt]` (LSB first), clear `baud_cnt`, and increment `bit_cnt`. After bit 7 is sampled, go to STOP.
- STOP: at `baud_cnt` == BAUD_DIV-1, sample the line.
  - Line high: load `dout` from `shift`, pulse `dout_vld`, and pulse the matching `cmd_*` output (if any).
  - Line low: pulse `frame_err` only. `dout` is unchanged and no command is issued.
  - In both cases, go to IDLE.

Width and arithmetic rules:
- `baud_cnt` width is $clog2(BAUD_DIV). It must never exceed BAUD_DIV-1.
- `bit_cnt` is 3 bits.

Boundary conditions:
- Line held low after a framing error (break condition): no new frame starts until the line returns high and then falls again, because only an edge starts a frame.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit. The next start edge, up to half a bit later, is detected normally.
- `rst_n` asserted mid-frame: all state clears immediately and the partial byte is discarded. After release, the block waits for a fresh start edge. A low `rx` at release does not start a frame.
- `rx` stuck high: no outputs.
- Unrecognized byte value: `dout_vld` pulses, all `cmd_*` outputs stay 0.

## Timing

- Reset values: `dout` = 8'h00; `dout_vld`, `frame_err`, `cmd_led`, `cmd_beep` = 0; state = IDLE.
- All outputs are registered. Every pulse is exactly 1 clk wide.
- Latency from the `rx` falling edge to `dout_vld`: 3 (synchronizer plus edge register) + BIT_HALF + 9·BAUD_DIV cycles. That is 4126 cycles at the defaults; the bench tolerance is ±2.
- Sampling points fall at the bit centres, ±1 cycle from the synchronizer delay.
- Baud-rate tolerance is ±2% cumulative over 10 bits.
- `dout_vld` and `frame_err` are never high in the same cycle.

## Structure

Shared package `uart_pkg`:
- state encoding constants IDLE/START/DATA/STOP;
- the `BAUD_DIV` calculation, so it is shared with `uart_tx`;
- default command byte constants CMD_LED and CMD_BEEP.

Sub-module:
- `uart_cmd_dec` is the natural split. It is purely registered: it takes `dout`/`dout_vld` and produces the `cmd_*` pulses one cycle later.
- If it is split out, the `cmd_*` latency becomes `dout_vld` + 1. The parent then delays `dout_vld` by one cycle so the pulses remain coincident.
- The UART core stays in `uart_rx_cmd`.

## Test plan

- Reset then idle line: `rx` = 1 for 10 000 cycles → every output stays 0 and `dout` = 8'h00.
- Single frame 8'hA5 at 115200 → `dout` = 8'hA5 and `dout_vld` pulses once, 4126±2 cycles after the start edge. `cmd_*` stay 0.
- Frame 8'h31, then frame 8'h32 back-to-back with no idle gap → `dout_vld` pulses twice. `cmd_led` fires with the first pulse, `cmd_beep` with the second.
- Frame 8'h31 with the stop bit forced low → `frame_err` pulses once, `dout` keeps its prior value, `cmd_led` = 0. Holding `rx` low for 5000 more cycles produces no further pulses.
- 100-cycle low glitch on an idle line → false start is rejected: no `dout_vld`, no `frame_err`, and state is IDLE 217 cycles later.
- `rst_n` pulsed low during bit 4 of frame 8'h31, then a clean frame 8'h55 → no output for the aborted frame. The second frame gives `dout` = 8'h55 with a single `dout_vld`.
